// File: rtl/int_arbiter_pkg.sv
// Shared state type and width helper for the interrupt arbiter.
package int_pkg;

    typedef enum logic [1:0] {IDLE, SIGNAL, RELEASE} int_state_t;

    // Source ID width; never narrower than one bit.
    function automatic int unsigned id_width(input int unsigned n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/int_arbiter_rr_pick.sv
// Combinational request picker: rotate by the priority pointer, take the lowest
// set bit, rotate the result back. With rr_en low the pointer is forced to 0.
module rr_pick import int_pkg::*; #(
    parameter int unsigned N_SRC = 4,
    localparam int unsigned IDW  = id_width(N_SRC)
) (
    input  logic [N_SRC-1:0] req,
    input  logic [IDW-1:0]   ptr,
    input  logic             rr_en,
    output logic [IDW-1:0]   grant_id,
    output logic             any
);

    logic [N_SRC-1:0] rot;
    logic [IDW-1:0]   base;
    logic [IDW-1:0]   rel_id;

    always_comb begin
        base = rr_en ? ptr : '0;
        for (int unsigned i = 0; i < N_SRC; i++) begin
            rot[i] = req[IDW'((i + 32'(base)) % N_SRC)];
        end

        any    = |req;
        rel_id = '0;
        for (int i = int'(N_SRC) - 1; i >= 0; i--) begin
            if (rot[i]) begin
                rel_id = IDW'(i);
            end
        end
        grant_id = IDW'((32'(rel_id) + 32'(base)) % N_SRC);
    end

endmodule

// File: rtl/int_arbiter.sv
// Interrupt arbiter: shares one CPU interrupt line among N_SRC request/ack
// sources, with a CPU-writable enable mask and fixed or round-robin priority.
module int_arbiter import int_pkg::*; #(
    parameter int unsigned N_SRC       = 4,
    parameter int unsigned ROUND_ROBIN = 1,
    parameter int unsigned REL_TIMEOUT = 15,
    localparam int unsigned IDW        = id_width(N_SRC)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_SRC-1:0] src_irq,
    output logic [N_SRC-1:0] src_ack,
    input  logic             mask_we,
    input  logic [N_SRC-1:0] mask_wdata,
    output logic [N_SRC-1:0] mask,
    output logic [N_SRC-1:0] pending,
    output logic             cpu_int,
    input  logic             cpu_ack,
    output logic [IDW-1:0]   vec_id,
    output logic             err_timeout
);

    localparam int unsigned CW = (REL_TIMEOUT > 1) ? $clog2(REL_TIMEOUT) : 1;
    // Last counter value before the release wait is abandoned.
    localparam logic [CW-1:0] CntLast = CW'(REL_TIMEOUT - 1);

    int_state_t       state_q, state_d;
    logic [N_SRC-1:0] src_ack_q, src_ack_d;
    logic [N_SRC-1:0] mask_q, mask_d;
    logic             cpu_int_q, cpu_int_d;
    logic [IDW-1:0]   vec_id_q, vec_id_d;
    logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             err_q, err_d;

    logic [IDW-1:0]   grant_id;
    logic             grant_any;
    logic [IDW-1:0]   next_ptr;
    logic             rr_en;

    assign pending = src_irq & mask_q;
    assign rr_en   = (ROUND_ROBIN != 0);

    rr_pick #(
        .N_SRC(N_SRC)
    ) u_rr_pick (
        .req     (pending),
        .ptr     (rr_ptr_q),
        .rr_en   (rr_en),
        .grant_id(grant_id),
        .any     (grant_any)
    );

    assign next_ptr = (vec_id_q == IDW'(N_SRC - 1)) ? '0 : vec_id_q + IDW'(1);

    always_comb begin
        state_d   = state_q;
        src_ack_d = src_ack_q;
        cpu_int_d = cpu_int_q;
        vec_id_d  = vec_id_q;
        rr_ptr_d  = rr_ptr_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        mask_d    = mask_we ? mask_wdata : mask_q;

        unique case (state_q)
            IDLE: begin
                if (grant_any) begin
                    state_d   = SIGNAL;
                    vec_id_d  = grant_id;
                    cpu_int_d = 1'b1;
                end
            end
            SIGNAL: begin
                // CPU ack takes precedence over a simultaneous withdrawal.
                if (cpu_ack) begin
                    state_d             = RELEASE;
                    cpu_int_d           = 1'b0;
                    src_ack_d           = '0;
                    src_ack_d[vec_id_q] = 1'b1;
                    cnt_d               = '0;
                end else if (!src_irq[vec_id_q]) begin
                    state_d   = IDLE;
                    cpu_int_d = 1'b0;
                end
            end
            RELEASE: begin
                if (!src_irq[vec_id_q] || cnt_q == CntLast) begin
                    err_d     = err_q | src_irq[vec_id_q];
                    state_d   = IDLE;
                    src_ack_d = '0;
                    cnt_d     = '0;
                    rr_ptr_d  = next_ptr;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            src_ack_q <= '0;
            mask_q    <= '1;
            cpu_int_q <= 1'b0;
            vec_id_q  <= '0;
            rr_ptr_q  <= '0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            src_ack_q <= src_ack_d;
            mask_q    <= mask_d;
            cpu_int_q <= cpu_int_d;
            vec_id_q  <= vec_id_d;
            rr_ptr_q  <= rr_ptr_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
        end
    end

    assign src_ack     = src_ack_q;
    assign mask        = mask_q;
    assign cpu_int     = cpu_int_q;
    assign vec_id      = vec_id_q;
    assign err_timeout = err_q;

endmodule

// File: doc/int_arbiter.md
Name: int_arbiter

Overview:
Interrupt controller that shares the single CPU interrupt line among N_SRC level-style peripheral interrupt sources (switch bank, timer, UART, etc.). It has a 4-phase handshake with each source: the source raises irq, the controller forwards ack, and the source drops irq. It latches the winning source ID for the CPU ISR to read, holds a CPU-writable enable mask, and arbitrates with fixed or round-robin priority. It sits between the peripheral interrupt/ack pins and the CPU interrupt/ack pins.

Parameters:
N_SRC, 4, number of interrupt sources (2..16)
ROUND_ROBIN, 1, 1 = rotating priority starting after the last served source; 0 = fixed priority, lowest index wins
REL_TIMEOUT, 15, max cycles in RELEASE waiting for the source to drop irq

Ports:
clk  in  1  system clock, all logic on posedge
reset  in  1  synchronous, active-high reset
src_irq  in  N_SRC  per-source interrupt request; held high until acked
src_ack  out  N_SRC  per-source acknowledge, one-hot or zero
mask_we  in  1  CPU write strobe for the enable mask
mask_wdata  in  N_SRC  new mask value; 1 = source enabled
mask  out  N_SRC  current enable mask
pending  out  N_SRC  combinational src_irq & mask
cpu_int  out  1  interrupt to CPU
cpu_ack  in  1  CPU acknowledge, sampled while cpu_int=1
vec_id  out  IDW = max(1, clog2(N_SRC))  ID of the granted source, stable from cpu_int rise until the next grant
err_timeout  out  1  sticky; set on RELEASE timeout; cleared only by reset

Behaviour:
- Reset values (synchronous, one edge): state=IDLE, cpu_int=0, src_ack=0, vec_id=0, mask=all ones, rr_ptr=0, err_timeout=0, timeout counter=0.
- Reset mid-operation aborts any grant immediately. src_ack and cpu_int are 0 in the cycle after reset is sampled. No drop-of-irq wait is performed.
- All outputs except pending are registered.
- FSM states: IDLE, SIGNAL, RELEASE.
- IDLE:
  - If pending != 0 at a clock edge, pick the winner (see arbitration), latch vec_id, go to SIGNAL.
  - cpu_int=1 in the first cycle of SIGNAL, giving 1-cycle latency from a sampled irq to cpu_int.
  - cpu_ack in IDLE is ignored.
- Arbitration:
  - ROUND_ROBIN=0: lowest set index of pending.
  - ROUND_ROBIN=1: first set index searching rr_ptr, rr_ptr+1, … modulo N_SRC.
  - rr_ptr becomes (vec_id+1) mod N_SRC when leaving RELEASE. It wraps from N_SRC-1 to 0.
- SIGNAL:
  - cpu_int=1.
  - If cpu_ack=1: go to RELEASE and set src_ack[vec_id]=1, cpu_int=0 at the same edge.
  - Else if src_irq[vec_id]=0 (spurious withdrawal): go to IDLE with cpu_int=0 and no src_ack.
  - If cpu_ack and the irq drop occur in the same cycle, cpu_ack wins and the FSM goes to RELEASE.
  - Masking the granted source while in SIGNAL does not cancel the grant.
- RELEASE:
  - src_ack[vec_id]=1; the counter increments each cycle.
  - If src_irq[vec_id]=0: go to IDLE, src_ack=0, counter=0.
  - Else if counter reaches REL_TIMEOUT: set err_timeout, go to IDLE, src_ack=0.
  - A source still requesting after a timeout is re-arbitrated normally.
  - cpu_ack in RELEASE is ignored.
- Re-arbitration happens in the IDLE cycle after RELEASE, so there is at least 1 idle cycle between grants.
- Mask:
  - mask_we=1 loads mask_wdata at the edge.
  - The new mask affects pending in the next cycle.
  - A mask write coinciding with arbitration uses the old mask.

Decomposition:
- Package int_pkg: typedef enum logic [1:0] {IDLE, SIGNAL, RELEASE} int_state_t; function id_width(n) returning IDW.
- One sub-module rr_pick: combinational, parameterised by N_SRC.
  - Inputs: req, ptr, rr_en.
  - Outputs: grant_id, any.
  - Implements both priority modes via rotate, priority-encode, un-rotate.
- int_arbiter holds the FSM, mask register, timeout counter and output registers.

Test Plan:
1. Single source: src_irq[2]↑ sampled at edge 5 -> cpu_int=1, vec_id=2 after edge 5. cpu_ack at edge 9 -> src_ack=4'b0100, cpu_int=0 after edge 9. src_irq[2]↓ sampled at edge 11 -> src_ack=0 after edge 11, state IDLE.
2. Priority, with src_irq[0] and src_irq[3] asserted together:
   - ROUND_ROBIN=0: first grant vec_id=0, next grant vec_id=3.
   - ROUND_ROBIN=1 with rr_ptr=1 (after serving source 0): vec_id=3 granted before 0. Then 0 is granted via wrap-around.
3. Mask: mask_wdata=4'b1110 with mask_we, then src_irq[0]=1 -> pending=0, cpu_int stays 0 for 20 cycles. Write 4'b1111 -> pending=4'b0001 next cycle, cpu_int=1 one cycle later.
4. Timeout: source 1 keeps src_irq high after ack -> src_ack[1] stays high 15 cycles, then err_timeout=1, src_ack=0, IDLE. Source 1 is re-granted next cycle; err_timeout stays 1.
5. Spurious withdrawal: src_irq[1] drops in SIGNAL without cpu_ack -> cpu_int=0 next cycle, src_ack never asserted.
6. Reset mid-RELEASE: reset=1 one cycle -> src_ack=0, cpu_int=0, mask=4'b1111, err_timeout=0, vec_id=0 after that edge. A still-high irq is re-granted after reset deasserts.
